// File: rtl/mbist_fault_mem_pkg.sv
// mbist_fault_pkg: fault type codes and the slot record shared by
// the fault-injecting memory model and its per-slot logic.
package mbist_fault_pkg;

  localparam int SLOT_AW = 32;
  localparam int SLOT_BW = 8;
  localparam int FT_W    = 3;

  typedef enum logic [FT_W-1:0] {
    FT_NONE   = 3'd0,
    FT_SA0    = 3'd1,
    FT_SA1    = 3'd2,
    FT_TF_UP  = 3'd3,
    FT_TF_DN  = 3'd4,
    FT_CF_INV = 3'd5
  } fault_e;

  // Fields are held at fixed maximum widths so one record fits any memory shape
  typedef struct packed {
    logic [FT_W-1:0]    ftype;
    logic [SLOT_AW-1:0] vaddr;
    logic [SLOT_BW-1:0] vbit;
    logic [SLOT_AW-1:0] aaddr;
    logic [SLOT_BW-1:0] abit;
  } slot_t;

  function automatic logic ft_active(input logic [FT_W-1:0] t);
    return (t >= FT_SA0) && (t <= FT_CF_INV);
  endfunction

endpackage

// File: rtl/mbist_fault_mem_if.sv
// mbist_fault_mem_if: RA1SHD-style access port plus fault configuration
// and observation signals of the fault-injecting memory model.
interface mbist_fault_mem_if #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int NUM_FAULTS = 4,
  parameter int CNT_W      = 16
);
  localparam int IDX_W = $clog2(NUM_FAULTS);
  localparam int BIT_W = $clog2(DATA_W);

  logic                  CEN;
  logic                  WEN;
  logic                  OEN;
  logic [ADDR_W-1:0]     A;
  logic [DATA_W-1:0]     D;
  logic                  CFG_EN;
  logic [IDX_W-1:0]      CFG_IDX;
  logic [2:0]            CFG_TYPE;
  logic [ADDR_W-1:0]     CFG_ADDR;
  logic [BIT_W-1:0]      CFG_BIT;
  logic [ADDR_W-1:0]     CFG_AGG_ADDR;
  logic [BIT_W-1:0]      CFG_AGG_BIT;
  logic [NUM_FAULTS-1:0] FAULT_HIT;
  logic [CNT_W-1:0]      HIT_CNT;

  modport master (
    output CEN, WEN, OEN, A, D,
    output CFG_EN, CFG_IDX, CFG_TYPE, CFG_ADDR,
    output CFG_BIT, CFG_AGG_ADDR, CFG_AGG_BIT,
    input  FAULT_HIT, HIT_CNT
  );

  modport slave (
    input  CEN, WEN, OEN, A, D,
    input  CFG_EN, CFG_IDX, CFG_TYPE, CFG_ADDR,
    input  CFG_BIT, CFG_AGG_ADDR, CFG_AGG_BIT,
    output FAULT_HIT, HIT_CNT
  );
endinterface

// File: rtl/mbist_fault_mem_slot.sv
// mbist_fault_slot: one fault slot; holds its record and produces the
// per-access force masks, coupling toggle request and hit pulse.
module mbist_fault_slot
  import mbist_fault_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              i_cfg_we,
  input  slot_t             i_cfg,
  input  logic              i_acc,
  input  logic              i_wr,
  input  logic [ADDR_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_d,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_new,
  output logic [DATA_W-1:0] o_force,
  output logic [DATA_W-1:0] o_val,
  output logic              o_tog,
  output logic [ADDR_W-1:0] o_vaddr,
  output logic [DATA_W-1:0] o_vmask,
  output logic              o_match,
  output logic              o_hit
);

  slot_t             r_slot;
  logic              w_vsel;
  logic              w_ob;
  logic              w_db;
  logic              w_fhit;
  logic              w_sa0;
  logic              w_sa1;
  logic              w_tfu;
  logic              w_tfd;
  logic [DATA_W-1:0] w_vbm;
  logic [DATA_W-1:0] w_abm;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)         r_slot <= '0;
    else if (i_cfg_we) r_slot <= i_cfg;
  end

  assign w_vsel = i_acc && (r_slot.vaddr == SLOT_AW'(i_a));
  assign w_vbm  = DATA_W'(1) << r_slot.vbit;
  assign w_abm  = DATA_W'(1) << r_slot.abit;
  assign w_ob   = |(i_old & w_vbm);
  assign w_db   = |(i_d & w_vbm);

  assign w_sa0 = w_vsel && (r_slot.ftype == FT_SA0);
  assign w_sa1 = w_vsel && (r_slot.ftype == FT_SA1);
  assign w_tfu = w_vsel && (r_slot.ftype == FT_TF_UP);
  assign w_tfd = w_vsel && (r_slot.ftype == FT_TF_DN);

  // Aggressor change is judged against the word after stuck/transition masks
  assign o_tog = i_acc && i_wr
              && (r_slot.ftype == FT_CF_INV)
              && (r_slot.aaddr == SLOT_AW'(i_a))
              && |((i_old ^ i_new) & w_abm);

  always_comb begin
    o_force = '0;
    o_val   = '0;
    w_fhit  = 1'b0;
    unique case (1'b1)
      w_sa0: begin
        o_force = w_vbm;
        w_fhit  = !i_wr || w_db;
      end
      w_sa1: begin
        o_force = w_vbm;
        o_val   = w_vbm;
        w_fhit  = !i_wr || !w_db;
      end
      w_tfu: if (i_wr && !w_ob && w_db) begin
        o_force = w_vbm;
        w_fhit  = 1'b1;
      end
      w_tfd: if (i_wr && w_ob && !w_db) begin
        o_force = w_vbm;
        o_val   = w_vbm;
        w_fhit  = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_hit   = w_fhit || o_tog;
  assign o_match = w_vsel && ft_active(r_slot.ftype);
  assign o_vaddr = r_slot.vaddr[ADDR_W-1:0];
  assign o_vmask = w_vbm;

endmodule

// File: rtl/mbist_fault_mem.sv
// mbist_fault_mem: behavioural single-port SRAM with a programmable
// fault table for exercising MBIST controllers.
module mbist_fault_mem
  import mbist_fault_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int NUM_FAULTS = 4,
  parameter int CNT_W      = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  mbist_fault_mem_if.slave  bus,
  output wire [DATA_W-1:0]  Q
);

  localparam int N     = NUM_FAULTS;
  localparam int IDX_W = $clog2(NUM_FAULTS);

  logic [DATA_W-1:0]         r_mem [2**ADDR_W];
  logic [DATA_W-1:0]         r_q;
  logic [N-1:0]              r_hit;
  logic [CNT_W-1:0]          r_cnt;
  logic                      w_acc;
  logic                      w_wr;
  logic                      w_rd;
  logic [DATA_W-1:0]         w_old;
  logic [DATA_W-1:0]         w_new;
  logic [DATA_W-1:0]         w_rdat;
  slot_t                     w_cfg;
  logic [N-1:0]              w_cfg_we;
  logic [N-1:0]              w_tog;
  logic [N-1:0]              w_match;
  logic [N-1:0]              w_pulse;
  logic [N-1:0][DATA_W-1:0]  w_force;
  logic [N-1:0][DATA_W-1:0]  w_val;
  logic [N-1:0][DATA_W-1:0]  w_vmask;
  logic [N-1:0][DATA_W-1:0]  w_vacc;
  logic [N-1:0][DATA_W-1:0]  w_vdat;
  logic [N-1:0][ADDR_W-1:0]  w_vaddr;

  assign w_acc = !bus.CEN;
  assign w_wr  = w_acc && !bus.WEN;
  assign w_rd  = w_acc && bus.WEN;
  assign w_old = r_mem[bus.A];

  assign w_cfg = '{
    ftype: bus.CFG_TYPE,
    vaddr: SLOT_AW'(bus.CFG_ADDR),
    vbit:  SLOT_BW'(bus.CFG_BIT),
    aaddr: SLOT_AW'(bus.CFG_AGG_ADDR),
    abit:  SLOT_BW'(bus.CFG_AGG_BIT)
  };

  for (genvar g = 0; g < N; g++) begin : g_slot
    assign w_cfg_we[g] = bus.CFG_EN && (bus.CFG_IDX == IDX_W'(g));
    mbist_fault_slot #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
    ) u_slot (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .i_cfg_we (w_cfg_we[g]),
      .i_cfg    (w_cfg),
      .i_acc    (w_acc),
      .i_wr     (w_wr),
      .i_a      (bus.A),
      .i_d      (bus.D),
      .i_old    (w_old),
      .i_new    (w_new),
      .o_force  (w_force[g]),
      .o_val    (w_val[g]),
      .o_tog    (w_tog[g]),
      .o_vaddr  (w_vaddr[g]),
      .o_vmask  (w_vmask[g]),
      .o_match  (w_match[g]),
      .o_hit    (w_pulse[g])
    );
  end

  // Later slots override earlier ones bit by bit
  always_comb begin
    w_new  = bus.D;
    w_rdat = w_old;
    for (int i = 0; i < N; i++) begin
      w_new  = (w_new & ~w_force[i]) | (w_val[i] & w_force[i]);
      w_rdat = (w_rdat & ~w_force[i]) | (w_val[i] & w_force[i]);
    end
  end

  // Coupling toggles aimed at one victim word XOR together
  always_comb begin
    w_vacc = '0;
    w_vdat = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++)
        if (w_tog[j] && (w_vaddr[j] == w_vaddr[i]))
          w_vacc[i] = w_vacc[i] ^ w_vmask[j];
      w_vdat[i] = ((w_vaddr[i] == bus.A) ? w_new : r_mem[w_vaddr[i]])
                ^ w_vacc[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RSTN && w_wr) begin
      r_mem[bus.A] <= w_new;
      for (int i = 0; i < N; i++)
        if (w_tog[i]) r_mem[w_vaddr[i]] <= w_vdat[i];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_q   <= '0;
      r_hit <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rd) r_q <= w_rdat;
      r_hit <= (r_hit | w_pulse) & ~w_cfg_we;
      if (|w_match && !(&r_cnt)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign Q             = bus.OEN ? {DATA_W{1'bz}} : r_q;
  assign bus.FAULT_HIT = r_hit;
  assign bus.HIT_CNT   = r_cnt;

endmodule

// File: tb/tb_mbist_fault_mem.sv
// tb_mbist_fault_mem: directed and randomized checks of the fault
// memory against a word/bit level reference model.
module tb_mbist_fault_mem;

  localparam int NF      = 4;
  localparam int CNT_MAX = 65535;

  logic        clk;
  logic        rstn;
  wire  [31:0] q;

  mbist_fault_mem_if #(
    .ADDR_W(12), .DATA_W(32), .NUM_FAULTS(NF), .CNT_W(16)
  ) bus ();

  mbist_fault_mem #(
    .ADDR_W(12), .DATA_W(32), .NUM_FAULTS(NF), .CNT_W(16)
  ) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus),
    .Q    (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mm [4096];
  int          s_t  [NF];
  int          s_va [NF];
  int          s_vb [NF];
  int          s_aa [NF];
  int          s_ab [NF];
  logic [3:0]  mhit;
  int          mcnt;
  logic [31:0] mq;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_hit"}, 32'(bus.FAULT_HIT), 32'(mhit));
    chk({tag, "_cnt"}, 32'(bus.HIT_CNT), 32'(mcnt));
  endtask

  task automatic m_reset();
    for (int i = 0; i < NF; i++) s_t[i] = 0;
    mhit = '0;
    mcnt = 0;
    mq   = '0;
  endtask

  task automatic m_cnt(input int a);
    bit any;
    any = 1'b0;
    for (int i = 0; i < NF; i++)
      if (s_t[i] >= 1 && s_t[i] <= 5 && s_va[i] == a) any = 1'b1;
    if (any && mcnt < CNT_MAX) mcnt++;
  endtask

  task automatic m_write(input int a, input logic [31:0] d);
    logic [31:0] nw;
    int tva[$];
    int tvb[$];
    int b;
    nw = d;
    m_cnt(a);
    for (int i = 0; i < NF; i++) begin
      b = s_vb[i];
      if (s_va[i] == a) begin
        case (s_t[i])
          1: begin nw[b] = 1'b0; if (d[b]) mhit[i] = 1'b1; end
          2: begin nw[b] = 1'b1; if (!d[b]) mhit[i] = 1'b1; end
          3: if (!mm[a][b] && d[b]) begin nw[b] = 1'b0; mhit[i] = 1'b1; end
          4: if (mm[a][b] && !d[b]) begin nw[b] = 1'b1; mhit[i] = 1'b1; end
          default: ;
        endcase
      end
    end
    for (int i = 0; i < NF; i++)
      if (s_t[i] == 5 && s_aa[i] == a && mm[a][s_ab[i]] != nw[s_ab[i]]) begin
        tva.push_back(s_va[i]);
        tvb.push_back(s_vb[i]);
        mhit[i] = 1'b1;
      end
    mm[a] = nw;
    foreach (tva[k]) mm[tva[k]][tvb[k]] = !mm[tva[k]][tvb[k]];
  endtask

  task automatic m_read(input int a);
    logic [31:0] v;
    m_cnt(a);
    v = mm[a];
    for (int i = 0; i < NF; i++)
      if (s_va[i] == a && (s_t[i] == 1 || s_t[i] == 2)) begin
        v[s_vb[i]] = (s_t[i] == 2);
        mhit[i] = 1'b1;
      end
    mq = v;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.CEN = 1'b0; bus.WEN = 1'b0; bus.A = 12'(a); bus.D = d;
    cyc();
    bus.CEN = 1'b1; bus.WEN = 1'b1;
    m_write(a, d);
  endtask

  task automatic rd(input int a, input string tag);
    bus.CEN = 1'b0; bus.WEN = 1'b1; bus.A = 12'(a);
    cyc();
    bus.CEN = 1'b1;
    m_read(a);
    chk(tag, q, mq);
  endtask

  task automatic cfg(input int idx, input int t, input int va, input int vb,
                     input int aa, input int ab);
    bus.CFG_EN = 1'b1; bus.CFG_IDX = 2'(idx); bus.CFG_TYPE = 3'(t);
    bus.CFG_ADDR = 12'(va); bus.CFG_BIT = 5'(vb);
    bus.CFG_AGG_ADDR = 12'(aa); bus.CFG_AGG_BIT = 5'(ab);
    cyc();
    bus.CFG_EN = 1'b0;
    s_t[idx] = t; s_va[idx] = va; s_vb[idx] = vb;
    s_aa[idx] = aa; s_ab[idx] = ab;
    mhit[idx] = 1'b0;
  endtask

  initial begin
    int op;
    bus.CEN = 1'b1; bus.WEN = 1'b1; bus.OEN = 1'b0;
    bus.A = '0; bus.D = '0; bus.CFG_EN = 1'b0; bus.CFG_IDX = '0;
    bus.CFG_TYPE = '0; bus.CFG_ADDR = '0; bus.CFG_BIT = '0;
    bus.CFG_AGG_ADDR = '0; bus.CFG_AGG_BIT = '0;
    for (int i = 0; i < NF; i++) begin
      s_va[i] = 0; s_vb[i] = 0; s_aa[i] = 0; s_ab[i] = 0;
    end
    rstn = 1'b0;
    m_reset();
    #12;
    chk("reset_q", q, 32'h0);
    chk_state("reset");
    @(negedge clk);
    rstn = 1'b1;

    wr(12'h004, 32'hFFFF_FFFF);
    rd(12'h004, "plain_rd");
    chk_state("plain");

    wr(12'h005, 32'h1357_9BDF);
    cfg(0, 1, 12'h004, 17, 0, 0);
    wr(12'h004, 32'hFFFF_FFFF);
    rd(12'h004, "sa0_rd");
    chk_state("sa0");
    rd(12'h005, "sa0_other_rd");

    cfg(1, 3, 12'h010, 0, 0, 0);
    wr(12'h010, 32'h0);
    wr(12'h010, 32'h1);
    rd(12'h010, "tfup_rd");
    chk_state("tfup");
    cfg(1, 0, 12'h010, 0, 0, 0);
    chk_state("tfup_clear");
    wr(12'h010, 32'h1);
    rd(12'h010, "none_rd");

    wr(12'h020, 32'h0);
    wr(12'h030, 32'h0);
    cfg(2, 5, 12'h030, 5, 12'h020, 3);
    wr(12'h030, 32'h0);
    wr(12'h020, 32'h0);
    wr(12'h020, 32'h8);
    rd(12'h030, "cf_rd");
    chk_state("cf");
    wr(12'h020, 32'h8);
    rd(12'h030, "cf_norise_rd");
    rd(12'h020, "cf_aggr_rd");

    wr(12'h040, 32'h0000_1234);
    bus.CEN = 1'b0; bus.WEN = 1'b0; bus.A = 12'h040; bus.D = 32'hDEAD_BEEF;
    #2 rstn = 1'b0;
    m_reset();
    #1;
    chk("rst_async_q", q, 32'h0);
    chk_state("rst_async");
    @(posedge clk);
    @(negedge clk);
    chk("rst_hold_q", q, 32'h0);
    bus.CEN = 1'b1; bus.WEN = 1'b1;
    rstn = 1'b1;
    rd(12'h040, "rst_abort_rd");
    wr(12'h004, 32'hFFFF_FFFF);
    rd(12'h004, "rst_slots_rd");
    chk_state("rst_slots");

    bus.OEN = 1'b1;
    #1;
    n_chk++;
    assert (q !== mq) n_pass++;
    else $error("FAIL oen_hiz: got %h expected not %h", q, mq);
    bus.OEN = 1'b0;
    #1;
    chk("oen_restore", q, mq);

    for (int a = 0; a < 16; a++) wr(a, $urandom);
    for (int k = 0; k < 400; k++) begin
      op = $urandom_range(0, 9);
      if (op < 2)
        cfg($urandom_range(0, NF - 1), $urandom_range(0, 7),
            $urandom_range(0, 15), $urandom_range(0, 31),
            $urandom_range(0, 15), $urandom_range(0, 31));
      else if (op < 6)
        wr($urandom_range(0, 15), $urandom);
      else
        rd($urandom_range(0, 15), "rand_rd");
      chk_state("rand");
    end

    cfg(3, 2, 12'h000, 7, 0, 0);
    wr(12'h000, 32'h0);
    bus.CEN = 1'b0; bus.WEN = 1'b1; bus.A = 12'h000;
    for (int k = 0; k < CNT_MAX + 6; k++) begin
      @(posedge clk);
      m_read(0);
    end
    @(negedge clk);
    bus.CEN = 1'b1;
    chk("sat_q", q, mq);
    chk("sat_cnt", 32'(bus.HIT_CNT), 32'(CNT_MAX));
    chk_state("sat");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
